instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 24, SHALL set the instruction address width, matching the program counter output.
REQ-002 Parameter INS_W, default 24, SHALL set the instruction word width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fetch_en  input  1  SHALL enable issuing new fetches.
REQ-006 flush  input  1  SHALL discard the held and in-flight instruction (branch/jump taken).
REQ-007 pc_addr  input  ADDR_W  SHALL carry the current program counter value.
REQ-008 pc_inc  output  1  SHALL be a one-cycle increment pulse to the program counter.
REQ-009 imem_req  output  1  SHALL be the IMEM read request.
REQ-010 imem_addr  output  ADDR_W  SHALL be the IMEM read address.
REQ-011 imem_ready  input  1  SHALL be IMEM request acceptance.
REQ-012 imem_valid  input  1  SHALL mark imem_rdata as valid.
REQ-013 imem_rdata  input  INS_W  SHALL be the IMEM read data.
REQ-014 ir_out  output  INS_W  SHALL be the instruction register, feeding the decoder.
REQ-015 ir_valid  output  1  SHALL indicate that ir_out holds a valid instruction.
REQ-016 dec_ready  input  1  SHALL indicate that the decoder accepts ir_out.

Function
REQ-017 The FSM SHALL have four states: IDLE, REQ, WAIT and HOLD.
REQ-018 Only one IMEM transaction SHALL be outstanding at any time.
REQ-019 IDLE -> REQ SHALL occur when fetch_en=1; on that transition, pc_addr SHALL be latched into imem_addr.
REQ-020 In REQ, imem_req SHALL be 1, with imem_addr held stable until imem_req&&imem_ready.
  - The cycle in which that handshake occurs SHALL take REQ -> WAIT.
REQ-021 imem_valid SHALL be sampled only in WAIT; IMEM latency is at least 1 cycle after acceptance.
REQ-022 WAIT with imem_valid=1 and no drop pending SHALL:
  - capture imem_rdata into ir_out;
  - set ir_valid=1 on the next edge;
  - assert pc_inc for exactly that one capture cycle;
  - go to HOLD.
REQ-023 The decoder handshake is ir_valid&&dec_ready. In HOLD, on that handshake:
  - ir_valid SHALL clear;
  - the next state SHALL be REQ, latching pc_addr, if fetch_en=1;
  - otherwise the next state SHALL be IDLE.
REQ-024 ir_out SHALL remain unchanged while ir_valid=1 and dec_ready=0.
REQ-025 fetch_en=0 SHALL NOT abort a started transaction; the block SHALL stop only after the HOLD handshake.
REQ-026 Flush in IDLE or HOLD SHALL:
  - clear ir_valid next cycle;
  - generate no pc_inc;
  - go to REQ if fetch_en=1, else IDLE.
REQ-027 Flush in REQ or WAIT SHALL set a drop flag, and the bus transaction SHALL complete normally.
  - The dropped response SHALL NOT load ir_out and SHALL NOT assert pc_inc.
  - The drop flag SHALL clear when the dropped response arrives; the FSM then goes to REQ (fetch_en=1) or IDLE.
REQ-028 A flush in the same cycle as a WAIT capture SHALL take priority: the data is dropped and there is no pc_inc.
REQ-029 A flush in the same cycle as a HOLD handshake SHALL behave as REQ-026.
REQ-030 pc_addr SHALL be re-latched on every entry to REQ, so a PC write made alongside flush is used by the next fetch.
REQ-031 Address wrap SHALL be the program counter's responsibility; this block SHALL pass address values unmodified.

Reset
REQ-032 While reset_n=0, independent of clk, the block SHALL force:
  - state=IDLE, drop flag=0;
  - imem_req=0, imem_addr=0;
  - ir_out=0, ir_valid=0, pc_inc=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction; a late imem_valid arriving in IDLE SHALL be ignored.
REQ-034 After reset_n rises, the first fetch SHALL start no earlier than the first edge with fetch_en=1.

Verification
REQ-035 Basic fetch: reset, pc_addr=0x000000, fetch_en=1, imem_ready=1, 1-cycle imem_valid with rdata=0xABCDEF.
  - Required: imem_addr=0x000000; one pc_inc pulse; ir_out=0xABCDEF with ir_valid=1.
REQ-036 Backpressure: dec_ready=0 for 5 cycles.
  - Required: ir_out/ir_valid stable; imem_req=0; no extra pc_inc; the next fetch latches pc_addr=0x000001 after dec_ready=1.
REQ-037 Stalled bus: imem_ready=0 for 3 cycles, pc_addr changed to 0x000010 meanwhile.
  - Required: imem_addr held at the latched value until acceptance.
REQ-038 Flush in WAIT: pc_addr written to 0x000200 together with flush; response 0x111111 arrives.
  - Required: 0x111111 never in ir_out; no pc_inc; next imem_addr=0x000200.
REQ-039 Async reset in WAIT: reset_n low mid-cycle.
  - Required: imem_req and ir_valid clear immediately; a following imem_valid is ignored; state IDLE.
REQ-040 Flush coincident with capture: flush=1 and imem_valid=1 in the same cycle.
  - Required: ir_valid=0, pc_inc=0, refetch from the current pc_addr.

Source files
------------

// File: rtl/instr_fetch_if.sv
// IMEM read bus between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_if #(
  parameter int ADDR_W = 24,
  parameter int INS_W  = 24
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_valid;
  logic [INS_W-1:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single outstanding IMEM read, instruction register
// with decoder handshake, and flush handling that drops in-flight responses.
module instr_fetch #(
  parameter int ADDR_W = 24,
  parameter int INS_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  instr_fetch_if.master     imem,
  output logic [INS_W-1:0]  ir_out,
  output logic              ir_valid,
  input  logic              dec_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t            r_state, w_state_next;
  logic              r_drop, w_drop_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [INS_W-1:0]  r_ir, w_ir_next;
  logic              r_ir_valid, w_ir_valid_next;
  logic              w_pc_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_drop     <= 1'b0;
      r_addr     <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_drop     <= w_drop_next;
      r_addr     <= w_addr_next;
      r_ir       <= w_ir_next;
      r_ir_valid <= w_ir_valid_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_drop_next     = r_drop;
    w_addr_next     = r_addr;
    w_ir_next       = r_ir;
    w_ir_valid_next = r_ir_valid;
    w_pc_inc        = 1'b0;

    case (r_state)
      IDLE: begin
        w_ir_valid_next = 1'b0;
        if (fetch_en) begin
          w_state_next = REQ;
          w_addr_next  = pc_addr;
        end
      end

      REQ: begin
        if (flush) w_drop_next = 1'b1;
        if (imem.imem_ready) w_state_next = WAIT;
      end

      WAIT: begin
        if (imem.imem_valid) begin
          // A flush arriving with the data wins over the capture.
          if (r_drop || flush) begin
            w_drop_next = 1'b0;
            if (fetch_en) begin
              w_state_next = REQ;
              w_addr_next  = pc_addr;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_ir_next       = imem.imem_rdata;
            w_ir_valid_next = 1'b1;
            w_pc_inc        = 1'b1;
            w_state_next    = HOLD;
          end
        end else if (flush) begin
          w_drop_next = 1'b1;
        end
      end

      HOLD: begin
        if (flush || dec_ready) begin
          w_ir_valid_next = 1'b0;
          if (fetch_en) begin
            w_state_next = REQ;
            w_addr_next  = pc_addr;
          end else begin
            w_state_next = IDLE;
          end
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign imem.imem_req  = (r_state == REQ);
  assign imem.imem_addr = r_addr;
  assign pc_inc         = w_pc_inc;
  assign ir_out         = r_ir;
  assign ir_valid       = r_ir_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch, backpressure, stall,
// flush, async reset and flush-with-capture scenarios.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int AW = 24;
  localparam int IW = 24;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          fetch_en  = 1'b0;
  logic          flush     = 1'b0;
  logic          dec_ready = 1'b0;
  logic [AW-1:0] pc_addr   = '0;
  logic          pc_wr_en  = 1'b0;
  logic [AW-1:0] pc_wr_val = '0;
  logic          pc_inc;
  logic [IW-1:0] ir_out;
  logic          ir_valid;
  int            lat       = 0;

  int tests = 0;
  int fails = 0;
  int pc_inc_cnt = 0;
  logic saw_bad = 1'b0;

  logic [AW-1:0] exp_addr_q[$];
  logic [IW-1:0] exp_ir_q[$];

  instr_fetch_if #(.ADDR_W(AW), .INS_W(IW)) bus();

  instr_fetch #(.ADDR_W(AW), .INS_W(IW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .pc_addr   (pc_addr),
    .pc_inc    (pc_inc),
    .imem      (bus),
    .ir_out    (ir_out),
    .ir_valid  (ir_valid),
    .dec_ready (dec_ready)
  );

  always #5 clk = ~clk;

  // Program counter: explicit writes override the increment pulse.
  always @(posedge clk) begin
    if (pc_wr_en)    pc_addr <= pc_wr_val;
    else if (pc_inc) pc_addr <= pc_addr + 1'b1;
  end

  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    case (a)
      24'h000000: return 24'hABCDEF;
      24'h000001: return 24'h123456;
      24'h000011: return 24'h111111;
      24'h000200: return 24'h222222;
      default:    return a ^ 24'h5A5A5A;
    endcase
  endfunction

  // IMEM responder: data appears lat cycles after the accepting edge.
  initial begin
    logic          hs;
    logic          pending;
    int            cnt;
    logic [AW-1:0] a;
    logic [AW-1:0] acc;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = '0;
    pending = 1'b0;
    cnt = 0;
    acc = '0;
    forever begin
      @(negedge clk);
      hs = bus.imem_req && bus.imem_ready;
      a  = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_valid = 1'b0;
      if (hs) begin
        pending = 1'b1;
        cnt     = lat;
        acc     = a;
      end
      if (pending) begin
        if (cnt == 0) begin
          bus.imem_valid = 1'b1;
          bus.imem_rdata = mem_data(acc);
          pending = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic monitor();
    logic [AW-1:0] ea;
    logic [IW-1:0] ei;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.imem_req && bus.imem_ready) begin
          if (exp_addr_q.size() == 0) begin
            check("unexpected_imem_req", 32'(bus.imem_addr), 32'hFFFF_FFFF);
          end else begin
            ea = exp_addr_q.pop_front();
            check("imem_addr", 32'(bus.imem_addr), 32'(ea));
          end
        end
        if (ir_valid && dec_ready) begin
          if (exp_ir_q.size() == 0) begin
            check("unexpected_ir", 32'(ir_out), 32'hFFFF_FFFF);
          end else begin
            ei = exp_ir_q.pop_front();
            check("ir_out", 32'(ir_out), 32'(ei));
          end
        end
        if (pc_inc) pc_inc_cnt++;
        if (ir_valid && ir_out == 24'h111111) saw_bad = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    fork
      monitor();
    join_none

    bus.imem_ready = 1'b1;

    // Reset state
    run(2);
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_ir_out", 32'(ir_out), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    check("no_fetch_without_en", 32'(bus.imem_req), 32'd0);

    // Basic fetch at 0x000000
    exp_addr_q.push_back(24'h000000);
    dec_ready = 1'b0;
    fetch_en  = 1'b1;
    run(3);
    @(negedge clk);
    check("basic_ir_valid", 32'(ir_valid), 32'd1);
    check("basic_ir_out", 32'(ir_out), 32'hABCDEF);
    check("basic_pc_inc_cnt", 32'(pc_inc_cnt), 32'd1);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_ir_valid", 32'(ir_valid), 32'd1);
      check("bp_ir_out", 32'(ir_out), 32'hABCDEF);
      check("bp_imem_req", 32'(bus.imem_req), 32'd0);
    end
    check("bp_pc_inc_cnt", 32'(pc_inc_cnt), 32'd1);
    exp_ir_q.push_back(24'hABCDEF);
    exp_addr_q.push_back(24'h000001);
    exp_ir_q.push_back(24'h123456);
    tick();
    dec_ready = 1'b1;
    tick();
    fetch_en = 1'b0;
    run(6);
    check("bp_pc_inc_cnt2", 32'(pc_inc_cnt), 32'd2);
    check("bp_pc_addr", 32'(pc_addr), 32'h000002);

    // Stalled bus with PC changing underneath
    exp_addr_q.push_back(24'h000002);
    exp_ir_q.push_back(24'h5A5A58);
    bus.imem_ready = 1'b0;
    fetch_en = 1'b1;
    tick();
    fetch_en  = 1'b0;
    pc_wr_val = 24'h000010;
    pc_wr_en  = 1'b1;
    tick();
    pc_wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_imem_req", 32'(bus.imem_req), 32'd1);
      check("stall_imem_addr", 32'(bus.imem_addr), 32'h000002);
      tick();
    end
    bus.imem_ready = 1'b1;
    run(6);
    check("stall_pc_inc_cnt", 32'(pc_inc_cnt), 32'd3);
    check("stall_pc_addr", 32'(pc_addr), 32'h000011);

    // Flush in WAIT together with PC write; 0x111111 must be dropped
    exp_addr_q.push_back(24'h000011);
    exp_addr_q.push_back(24'h000200);
    exp_ir_q.push_back(24'h222222);
    lat = 2;
    fetch_en = 1'b1;
    run(2);
    flush     = 1'b1;
    pc_wr_val = 24'h000200;
    pc_wr_en  = 1'b1;
    tick();
    flush    = 1'b0;
    pc_wr_en = 1'b0;
    lat      = 0;
    run(2);
    fetch_en = 1'b0;
    run(6);
    check("flushw_pc_inc_cnt", 32'(pc_inc_cnt), 32'd4);
    check("flushw_pc_addr", 32'(pc_addr), 32'h000201);
    check("flushw_no_dropped_ir", 32'(saw_bad), 32'd0);

    // Async reset while in WAIT; late imem_valid must be ignored
    exp_addr_q.push_back(24'h000201);
    lat = 3;
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_imem_req", 32'(bus.imem_req), 32'd0);
    check("arst_ir_valid", 32'(ir_valid), 32'd0);
    check("arst_imem_addr", 32'(bus.imem_addr), 32'd0);
    tick();
    reset_n = 1'b1;
    lat = 0;
    run(4);
    @(negedge clk);
    check("arst_late_ir_valid", 32'(ir_valid), 32'd0);
    check("arst_late_imem_req", 32'(bus.imem_req), 32'd0);
    check("arst_pc_inc_cnt", 32'(pc_inc_cnt), 32'd4);

    // Flush coincident with capture: drop and refetch same PC
    exp_addr_q.push_back(24'h000201);
    exp_addr_q.push_back(24'h000201);
    exp_ir_q.push_back(24'h5A585B);
    fetch_en = 1'b1;
    run(2);
    flush = 1'b1;
    @(negedge clk);
    check("fcap_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fcap_ir_valid", 32'(ir_valid), 32'd0);
    check("fcap_refetch_req", 32'(bus.imem_req), 32'd1);
    check("fcap_refetch_addr", 32'(bus.imem_addr), 32'h000201);
    fetch_en = 1'b0;
    run(5);
    check("fcap_pc_inc_cnt", 32'(pc_inc_cnt), 32'd5);
    check("fcap_pc_addr", 32'(pc_addr), 32'h000202);

    // Flush in HOLD with fetch disabled
    exp_addr_q.push_back(24'h000202);
    dec_ready = 1'b0;
    fetch_en  = 1'b1;
    tick();
    fetch_en = 1'b0;
    run(2);
    @(negedge clk);
    check("fhold_ir_valid", 32'(ir_valid), 32'd1);
    check("fhold_ir_out", 32'(ir_out), 32'h5A5858);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fhold_ir_cleared", 32'(ir_valid), 32'd0);
    check("fhold_imem_req", 32'(bus.imem_req), 32'd0);
    dec_ready = 1'b1;
    run(3);
    check("fhold_pc_inc_cnt", 32'(pc_inc_cnt), 32'd6);

    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("ir_queue_drained", 32'(exp_ir_q.size()), 32'd0);
    check("never_dropped_ir", 32'(saw_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
